// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg
//   Shared types and constants for the MEM-stage sequencer:
//   access-size encoding, control-bundle bit positions, FSM state
//   encoding and fault codes.
package mem_access_stage_pkg;

  // Access size, control_signals_M[3:2]
  typedef enum logic [1:0] {
    SZ_WORD  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_BYTE  = 2'b10,
    SZ_BYTEU = 2'b11
  } size_e;

  // control_signals_M = {size[1:0], MemWrite, MemRead}
  localparam int CM_READ    = 0;
  localparam int CM_WRITE   = 1;
  localparam int CM_SIZE_LO = 2;
  localparam int CM_SIZE_HI = 3;

  // control_signals_WB = {RegWrite, MemToReg}
  localparam int CWB_MEMTOREG = 0;
  localparam int CWB_REGWRITE = 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Combinational byte-lane logic for the data-memory bus.
//   Ports:
//     addr_lo, size        low address bits / size of the access being issued
//     store_data           store data from EX/MEM
//     be, wdata            byte enables and lane-replicated store data
//     misaligned           access violates its natural alignment
//     load_addr_lo/size    address bits / size latched with the outstanding request
//     rdata                read word from the bus
//     load_data            selected lane shifted to bit 0 and extended
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  input  logic [1:0]  load_addr_lo,
  input  size_e       load_size,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    be         = 4'b0000;
    wdata      = store_data;
    misaligned = 1'b0;
    case (size)
      SZ_WORD: begin
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      // signed and unsigned byte behave identically on the store side
      default: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
    endcase
  end

  always_comb begin
    shifted   = rdata >> {load_addr_lo, 3'b000};
    load_data = rdata;
    case (load_size)
      SZ_WORD:  load_data = rdata;
      SZ_HALF:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      SZ_BYTE:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      default:  load_data = {24'h000000, shifted[7:0]};
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM-stage sequencer: issues req/ack data-memory accesses for EX/MEM
//   loads/stores, stalls upstream while an access is outstanding, aborts
//   after TIMEOUT cycles without ack, and owns the MEM/WB register.
//   Ports:
//     clk, rst                 clock, synchronous active-low reset
//     result .. control_*      EX/MEM inputs
//     dmem_*                   data-memory bus (request side registered)
//     stall                    hold PC, IF/ID, ID/EX, EX/MEM
//     mem_data_out .. control_signals_WB_out   MEM/WB register
//     fault_out                one-cycle fault pulse (01 misalign, 10 timeout)
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic [31:0] write_data,
  input  logic [4:0]  RegDest,
  input  logic [3:0]  control_signals_M,
  input  logic [1:0]  control_signals_WB,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] mem_data_out,
  output logic [31:0] result_out,
  output logic [4:0]  RegDestOut,
  output logic [1:0]  control_signals_WB_out,
  output logic [1:0]  fault_out
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state, state_next;
  logic [7:0]  cnt;
  logic [1:0]  req_lo;
  size_e       req_size;

  logic        mem_rd, mem_wr, mem_op, misaligned, timeout_hit;
  size_e       size_in;
  logic [3:0]  be;
  logic [31:0] wdata, load_data;

  assign mem_rd      = control_signals_M[CM_READ];
  assign mem_wr      = control_signals_M[CM_WRITE];
  assign mem_op      = mem_rd | mem_wr;
  assign size_in     = size_e'(control_signals_M[CM_SIZE_HI:CM_SIZE_LO]);
  assign timeout_hit = (state == WAIT) && (cnt == CNT_LAST);

  mem_lane_align u_align (
    .addr_lo      (result[1:0]),
    .size         (size_in),
    .store_data   (write_data),
    .be           (be),
    .wdata        (wdata),
    .misaligned   (misaligned),
    .load_addr_lo (req_lo),
    .load_size    (req_size),
    .rdata        (dmem_rdata),
    .load_data    (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // An ack arriving on the timeout cycle completes the access normally.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !misaligned) begin
          stall      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        stall = !dmem_ack && !timeout_hit;
        if (dmem_ack || timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dmem_req               <= 1'b0;
      dmem_we                <= 1'b0;
      dmem_addr              <= '0;
      dmem_be                <= '0;
      dmem_wdata             <= '0;
      cnt                    <= '0;
      req_lo                 <= '0;
      req_size               <= SZ_WORD;
      mem_data_out           <= '0;
      result_out             <= '0;
      RegDestOut             <= '0;
      control_signals_WB_out <= '0;
      fault_out              <= FAULT_NONE;
    end else begin
      fault_out <= FAULT_NONE;
      case (state)
        IDLE: begin
          if (!mem_op) begin
            result_out             <= result;
            RegDestOut             <= RegDest;
            control_signals_WB_out <= control_signals_WB;
            mem_data_out           <= '0;
          end else begin
            control_signals_WB_out <= '0;
            if (misaligned) begin
              fault_out <= FAULT_MISALIGN;
            end else begin
              // MemRead wins when both are set
              dmem_req   <= 1'b1;
              dmem_we    <= mem_wr & ~mem_rd;
              dmem_addr  <= {result[31:2], 2'b00};
              dmem_be    <= be;
              dmem_wdata <= wdata;
              req_lo     <= result[1:0];
              req_size   <= size_in;
              cnt        <= '0;
            end
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            dmem_req               <= 1'b0;
            result_out             <= result;
            RegDestOut             <= RegDest;
            control_signals_WB_out <= control_signals_WB;
            mem_data_out           <= dmem_we ? 32'h0 : load_data;
          end else if (timeout_hit) begin
            dmem_req               <= 1'b0;
            control_signals_WB_out <= '0;
            fault_out              <= FAULT_TIMEOUT;
          end else begin
            cnt                    <= cnt + 8'd1;
            control_signals_WB_out <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
